// File: rtl/pi_bus_pkg.sv
// Shared types and widths for the Pi request path (command stage <-> bus access).
package pi_bus_pkg;

    localparam int unsigned PI_ADDR_W = 17;
    localparam int unsigned PI_DATA_W = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bus access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4,
        ST_DONE      = 3'd5
    } pi_state_e;

    // One latched Pi request
    typedef struct packed {
        logic                 rw_b;
        logic [PI_ADDR_W-1:0] addr;
        logic [PI_DATA_W-1:0] data;
    } pi_req_t;

endpackage

// File: rtl/pi_bus_access.sv
// Pi SRAM access sequencer: latches one request from the SPI command stage,
// waits for the Pi bus window and runs a single registered SRAM read/write.
// Every output is a register driven from the current state, so the pins lag
// the state by one clock and no input reaches an output combinationally.
module pi_bus_access
    import pi_bus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 3
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 pi_pending,
    input  logic                 pi_rw_b,
    input  logic [PI_ADDR_W-1:0] pi_addr,
    input  logic [PI_DATA_W-1:0] pi_data_in,
    output logic                 pi_done,
    output logic [PI_DATA_W-1:0] pi_data_out,
    input  logic                 slot_start,
    output logic                 bus_grant,
    output logic [PI_ADDR_W-1:0] ram_addr,
    output logic [PI_DATA_W-1:0] ram_data_out,
    input  logic [PI_DATA_W-1:0] ram_data_in,
    output logic                 ram_data_oe,
    output logic                 ram_oe_n,
    output logic                 ram_we_n
);

    localparam int unsigned    CNT_W    = $clog2(STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

    pi_state_e            r_state;
    pi_state_e            w_state_nxt;
    pi_req_t              r_req;
    pi_req_t              w_req_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_pending_q;
    logic                 w_rise;
    logic                 w_is_read;

    logic                 w_done_nxt;
    logic [PI_DATA_W-1:0] w_rdata_nxt;
    logic                 w_grant_nxt;
    logic [PI_ADDR_W-1:0] w_addr_nxt;
    logic [PI_DATA_W-1:0] w_wdata_nxt;
    logic                 w_data_oe_nxt;
    logic                 w_oe_n_nxt;
    logic                 w_we_n_nxt;

    assign w_rise    = pi_pending & ~r_pending_q;
    assign w_is_read = (r_req.rw_b == RW_READ);

    // State, request latch, strobe counter and pending edge detector
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_pending_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pending_q <= pi_pending;
        end
    end

    // Next-state and next-output decode from the current state
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_rdata_nxt   = pi_data_out;
        w_grant_nxt   = 1'b0;
        w_addr_nxt    = ram_addr;
        w_wdata_nxt   = ram_data_out;
        w_data_oe_nxt = 1'b0;
        w_oe_n_nxt    = 1'b1;
        w_we_n_nxt    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_req_nxt.rw_b = pi_rw_b;
                    w_req_nxt.addr = pi_addr;
                    w_req_nxt.data = pi_data_in;
                    w_state_nxt    = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_SLOT: begin
                // Abandon wins over a coincident window start
                if (!pi_pending) begin
                    w_state_nxt = ST_IDLE;
                end else if (slot_start) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_grant_nxt = 1'b1;
                w_addr_nxt  = r_req.addr;
                if (!w_is_read) begin
                    w_wdata_nxt   = r_req.data;
                    w_data_oe_nxt = 1'b1;
                end
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                w_grant_nxt = 1'b1;
                if (w_is_read) begin
                    w_oe_n_nxt = 1'b0;
                end else begin
                    w_we_n_nxt    = 1'b0;
                    w_data_oe_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // This edge closes the last oe_n-low cycle: sample read data here
                w_grant_nxt = 1'b1;
                if (w_is_read) begin
                    w_rdata_nxt = ram_data_in;
                end else begin
                    w_data_oe_nxt = 1'b1;
                end
                w_state_nxt = pi_pending ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                w_done_nxt = pi_pending;
                if (!pi_pending) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers; async reset also releases the strobes mid-access
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pi_done      <= 1'b0;
            pi_data_out  <= '0;
            bus_grant    <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            ram_data_oe  <= 1'b0;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
        end else begin
            pi_done      <= w_done_nxt;
            pi_data_out  <= w_rdata_nxt;
            bus_grant    <= w_grant_nxt;
            ram_addr     <= w_addr_nxt;
            ram_data_out <= w_wdata_nxt;
            ram_data_oe  <= w_data_oe_nxt;
            ram_oe_n     <= w_oe_n_nxt;
            ram_we_n     <= w_we_n_nxt;
        end
    end

endmodule

// File: tb/tb_pi_bus_access.sv
// Self-checking bench for pi_bus_access: reset, a vector table of requests
// with hand-derived expectations, then random requests scored against a
// transaction-level model of what the bus and the command stage should see.
module tb_pi_bus_access;
    import pi_bus_pkg::*;

    localparam int unsigned SC       = 3;
    localparam int unsigned ABT_NONE = 0;
    localparam int unsigned ABT_WAIT = 1;
    localparam int unsigned ABT_BUS  = 2;
    localparam int unsigned NTBL     = 8;
    localparam int unsigned NRND     = 40;

    logic        sys_clk;
    logic        reset_n;
    logic        pi_pending;
    logic        pi_rw_b;
    logic [16:0] pi_addr;
    logic [7:0]  pi_data_in;
    logic        pi_done;
    logic [7:0]  pi_data_out;
    logic        slot_start;
    logic        bus_grant;
    logic [16:0] ram_addr;
    logic [7:0]  ram_data_out;
    logic [7:0]  ram_data_in;
    logic        ram_data_oe;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [7:0]  ram_rd_byte;

    pi_bus_access #(.STROBE_CYCLES(SC)) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .pi_pending   (pi_pending),
        .pi_rw_b      (pi_rw_b),
        .pi_addr      (pi_addr),
        .pi_data_in   (pi_data_in),
        .pi_done      (pi_done),
        .pi_data_out  (pi_data_out),
        .slot_start   (slot_start),
        .bus_grant    (bus_grant),
        .ram_addr     (ram_addr),
        .ram_data_out (ram_data_out),
        .ram_data_in  (ram_data_in),
        .ram_data_oe  (ram_data_oe),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n)
    );

    // SRAM only drives the bus while output-enabled
    assign ram_data_in = ram_oe_n ? 8'h00 : ram_rd_byte;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        rw;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdbyte;
        bit          early_slot;
        int unsigned wait_n;
        int unsigned abort;
        int unsigned abort_at;
        int unsigned hold_n;
        bit          exp_access;
        bit          exp_done;
        int unsigned exp_lat;
        logic [7:0]  exp_dout;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [16:0] addr;
        logic [7:0]  data;
        int unsigned width;
        int unsigned glen;
        int unsigned doe;
        bit          stable;
    } acc_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned inv_err = 0;
    string       tag = "";
    acc_t        obs_q[$];
    acc_t        m_cur;
    bit          m_active = 1'b0;
    vec_t        tbl[NTBL];
    logic [7:0]  model_dout;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s_%s: actual=%0h required=%0h", tag, nm, act, exp);
        end
    endtask

    // Advance one clock, sample 1ns later and fold the bus pins into access records
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (!reset_n) begin
            m_active = 1'b0;
        end else begin
            if (!ram_oe_n && !ram_we_n) inv_err++;
            if (!bus_grant && (!ram_oe_n || !ram_we_n || ram_data_oe)) inv_err++;
            if (ram_data_oe && !ram_oe_n) inv_err++;
            if (bus_grant) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_cur = '{rw: 1'b0, addr: ram_addr, data: ram_data_out,
                              width: 0, glen: 0, doe: 0, stable: 1'b1};
                end else if (ram_addr !== m_cur.addr || ram_data_out !== m_cur.data) begin
                    m_cur.stable = 1'b0;
                end
                m_cur.glen++;
                if (!ram_oe_n) begin
                    m_cur.width++;
                    m_cur.rw = 1'b1;
                end
                if (!ram_we_n) m_cur.width++;
                if (ram_data_oe) m_cur.doe++;
            end else if (m_active) begin
                obs_q.push_back(m_cur);
                m_active = 1'b0;
            end
        end
    endtask

    function automatic vec_t mk(logic rw, logic [16:0] a, logic [7:0] wd, logic [7:0] rb,
                                bit es, int unsigned wn, int unsigned ab, int unsigned aat,
                                int unsigned hn, bit ea, bit ed, int unsigned lat,
                                logic [7:0] dout);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = wd; v.rdbyte = rb;
        v.early_slot = es; v.wait_n = wn; v.abort = ab; v.abort_at = aat;
        v.hold_n = hn; v.exp_access = ea; v.exp_done = ed; v.exp_lat = lat;
        v.exp_dout = dout;
        return v;
    endfunction

    // Drive one request through the block and score everything it produced
    task automatic run_vec(input vec_t v);
        int unsigned early_g;
        int unsigned lat;
        bit          seen;
        acc_t        r;
        early_g = 0; lat = 0; seen = 1'b0;
        ram_rd_byte = v.rdbyte;
        pi_rw_b     = v.rw;
        pi_addr     = v.addr;
        pi_data_in  = v.wdata;
        pi_pending  = 1'b1;
        slot_start  = v.early_slot;
        tick();
        slot_start  = 1'b0;
        if (bus_grant) early_g++;
        for (int i = 0; i < int'(v.wait_n); i++) begin
            tick();
            if (bus_grant) early_g++;
        end
        if (v.abort == ABT_WAIT) begin
            pi_pending = 1'b0;
            tick();
            if (bus_grant) early_g++;
        end
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        for (int c = 1; c <= int'(SC) + 8; c++) begin
            if (v.abort == ABT_BUS && c - 1 == int'(v.abort_at)) pi_pending = 1'b0;
            tick();
            if (pi_done && !seen) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        for (int i = 0; i < int'(v.hold_n); i++) tick();
        check("early_grant", 32'(early_g), 32'd0);
        check("done_seen", 32'(seen), 32'(v.exp_done));
        if (v.exp_done) check("done_latency", 32'(lat), 32'(v.exp_lat));
        check("done_held", 32'(pi_done), 32'(v.exp_done));
        pi_pending = 1'b0;
        tick();
        check("done_clear", 32'(pi_done), 32'd0);
        tick();
        tick();
        check("data_out", 32'(pi_data_out), 32'(v.exp_dout));
        check("access_count", 32'(obs_q.size()), 32'(v.exp_access));
        if (v.exp_access && obs_q.size() > 0) begin
            r = obs_q.pop_front();
            check("acc_rw", 32'(r.rw), 32'(v.rw));
            check("acc_addr", 32'(r.addr), 32'(v.addr));
            check("strobe_width", 32'(r.width), 32'(SC));
            check("grant_len", 32'(r.glen), 32'(SC + 2));
            check("data_oe_len", 32'(r.doe), (v.rw == RW_READ) ? 32'd0 : 32'(SC + 2));
            check("addr_data_stable", 32'(r.stable), 32'd1);
            if (v.rw == RW_WRITE) check("acc_wdata", 32'(r.data), 32'(v.wdata));
        end
        check("bus_rules", 32'(inv_err), 32'd0);
        obs_q.delete();
    endtask

    initial begin
        vec_t v;
        reset_n     = 1'b0;
        pi_pending  = 1'b0;
        pi_rw_b     = RW_READ;
        pi_addr     = '0;
        pi_data_in  = '0;
        slot_start  = 1'b0;
        ram_rd_byte = 8'h00;

        // Reset values
        tag = "reset";
        #12;
        check("pi_done", 32'(pi_done), 32'd0);
        check("pi_data_out", 32'(pi_data_out), 32'd0);
        check("bus_grant", 32'(bus_grant), 32'd0);
        check("ram_addr", 32'(ram_addr), 32'd0);
        check("ram_data_out", 32'(ram_data_out), 32'd0);
        check("ram_data_oe", 32'(ram_data_oe), 32'd0);
        check("ram_oe_n", 32'(ram_oe_n), 32'd1);
        check("ram_we_n", 32'(ram_we_n), 32'd1);
        #5 reset_n = 1'b1;
        tick();
        tick();

        // Reset in the middle of a write strobe
        tag = "reset_mid";
        pi_rw_b = RW_WRITE; pi_addr = 17'h18000; pi_data_in = 8'hA5; pi_pending = 1'b1;
        tick();
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        tick();
        tick();
        check("we_low_before", 32'(ram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("we_n", 32'(ram_we_n), 32'd1);
        check("oe_n", 32'(ram_oe_n), 32'd1);
        check("data_oe", 32'(ram_data_oe), 32'd0);
        check("grant", 32'(bus_grant), 32'd0);
        check("done", 32'(pi_done), 32'd0);
        pi_pending = 1'b0;
        tick();
        tick();
        #4 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_no_access", 32'(obs_q.size()), 32'd0);
        check("idle_grant", 32'(bus_grant), 32'd0);
        obs_q.delete();

        // Vector table: hand-derived expectations
        tbl[0] = mk(RW_WRITE, 17'h18000, 8'hA5, 8'h00, 1'b0, 2,  ABT_NONE, 0, 0,  1'b1, 1'b1, 6, 8'h00);
        tbl[1] = mk(RW_READ,  17'h01234, 8'h00, 8'h5A, 1'b0, 0,  ABT_NONE, 0, 0,  1'b1, 1'b1, 6, 8'h5A);
        tbl[2] = mk(RW_WRITE, 17'h00FFF, 8'h3C, 8'h11, 1'b1, 15, ABT_NONE, 0, 0,  1'b1, 1'b1, 6, 8'h5A);
        tbl[3] = mk(RW_WRITE, 17'h0AAAA, 8'h66, 8'h22, 1'b0, 1,  ABT_BUS,  1, 0,  1'b1, 1'b0, 6, 8'h5A);
        tbl[4] = mk(RW_READ,  17'h1FFFF, 8'h00, 8'hC3, 1'b0, 3,  ABT_BUS,  3, 0,  1'b1, 1'b0, 6, 8'hC3);
        tbl[5] = mk(RW_READ,  17'h05555, 8'h00, 8'h99, 1'b0, 4,  ABT_WAIT, 0, 0,  1'b0, 1'b0, 6, 8'hC3);
        tbl[6] = mk(RW_READ,  17'h00000, 8'h00, 8'h7E, 1'b0, 1,  ABT_NONE, 0, 50, 1'b1, 1'b1, 6, 8'h7E);
        tbl[7] = mk(RW_WRITE, 17'h00001, 8'hFF, 8'h33, 1'b0, 0,  ABT_NONE, 0, 0,  1'b1, 1'b1, 6, 8'h7E);
        for (int i = 0; i < int'(NTBL); i++) begin
            tag = $sformatf("tbl%0d", i);
            run_vec(tbl[i]);
        end

        // Random requests scored by a transaction-level model
        model_dout = tbl[NTBL-1].exp_dout;
        for (int i = 0; i < int'(NRND); i++) begin
            tag          = $sformatf("rnd%0d", i);
            v.rw         = 1'($urandom_range(0, 1));
            v.addr       = 17'($urandom);
            v.wdata      = 8'($urandom);
            v.rdbyte     = 8'($urandom);
            v.early_slot = ($urandom_range(0, 3) == 0);
            v.wait_n     = $urandom_range(0, 6);
            v.abort      = $urandom_range(0, 2);
            v.abort_at   = $urandom_range(0, SC + 1);
            v.hold_n     = $urandom_range(0, 3);
            // Model: a window always yields a full access unless abandoned
            // before it; done only when the request is still held after it.
            v.exp_access = (v.abort != ABT_WAIT);
            v.exp_done   = (v.abort == ABT_NONE);
            v.exp_lat    = SC + 3;
            if (v.exp_access && v.rw == RW_READ) model_dout = v.rdbyte;
            v.exp_dout   = model_dout;
            run_vec(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
